axis_histogram_accumulator: RTL and testbench
=============================================

// Module: axis_histogram_accumulator
// PURPOSE
//  Upstream stage of the USB controller. Bins detector hits into two 128-bin x 16-bit projections (y-axis, x-axis)
//  over a frame of FRAME_CYCLES clk cycles, then raises start_sending and serves bins combinationally by read index.
//  Start/stop/clear control comes from the USB host via the controller's 16-bit command word.
// PARAMETERS
//  FRAME_CYCLES  1_000_000  acquisition window per frame, in clk cycles; must be >= 200 and longer than one USB dump
//  DUMP_CYCLES   132        start_sending high time; must be >= 130, covering 1 arm cycle + 128 copy cycles + margin
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high
//  hit_valid         in   1   one detector hit this cycle
//  hit_x             in   7   hit x bin
//  hit_y             in   7   hit y bin
//  command           in   16  host command word from USB controller; asynchronous (CLK domain)
//  read_index_yaxis  in   7   bin select for data_yaxis
//  read_index_xaxis  in   7   bin select for data_xaxis
//  data_yaxis        out  16  y bin[read_index_yaxis]; combinational
//  data_xaxis        out  16  x bin[read_index_xaxis]; combinational
//  start_sending     out  1   frame-complete strobe to USB controller
//  acquiring         out  1   high in ACQUIRE
//  frame_count       out  16  frames dumped since clear; wraps FFFF->0
//  lost_hits         out  16  hits dropped outside ACQUIRE; saturates at FFFF
// BEHAVIOUR
//  Reset
//   - State = IDLE; all bins, frame timer, frame_count, lost_hits = 0; start_sending = 0; acquiring = 0.
//   - Reset mid-DUMP drops start_sending the next cycle. The USB controller tolerates this.
//  Command intake
//   - command passes through a 2-flop synchroniser.
//   - A new value is accepted only when two consecutive synchronised samples are equal and differ from the last accepted value.
//   - Action fires once per accepted change. Codes: NOOP=0, START=1, STOP=2, CLEAR=3. Other codes are ignored.
//  States
//   - IDLE:    START -> zero bins and timer, go ACQUIRE. CLEAR -> zero bins, frame_count, lost_hits.
//   - ACQUIRE: on hit_valid, bin_y[hit_y]++ and bin_x[hit_x]++, each saturating at FFFF.
//              STOP -> IDLE; bins retained, no dump.
//              Timer == FRAME_CYCLES-1 -> DUMP, start_sending=1 from the next cycle. A hit in that last cycle is counted.
//              CLEAR -> zero all bins and counters, stay ACQUIRE, restart timer.
//   - DUMP:    bins frozen; start_sending=1 for exactly DUMP_CYCLES cycles.
//              On the last DUMP cycle -> CLEARBINS, and frame_count++.
//   - CLEARBINS: one cycle; all bins zeroed, start_sending=0.
//              Go ACQUIRE, or IDLE if STOP is pending.
//  Hits outside ACQUIRE
//   - Any hit in IDLE, DUMP or CLEARBINS increments lost_hits (saturating); the bins are untouched.
//  Commands during DUMP/CLEARBINS
//   - Latched as pending; only the latest one is kept.
//   - Applied at ACQUIRE re-entry: STOP -> IDLE. CLEAR -> zeros the counters (bins are already zero). START -> ignored.
//  Simultaneous events
//   - Command action takes priority over frame end in the same cycle; STOP wins and no dump occurs.
//   - A hit in the same cycle as STOP is counted.
//  Read ports
//   - Pure combinational array reads, valid in every state.
//   - The USB controller samples them on the same clk edge that read_index is valid.
// STRUCTURE
//  autorad_pkg:
//   - CMD_NOOP/START/STOP/CLEAR codes, shared with UsbController's COMMAND_NOOP.
//   - BIN_COUNT=128, BIN_W=16, IDX_W=7.
//  Sub-module cmd_sync:
//   - 2-flop sync + stability/change detect.
//   - Outputs one-cycle start_p, stop_p, clear_p pulses.
//  Top: state machine, frame timer, two bin arrays with saturating increment.
// TESTING
//  1. Reset, command=1, 3 hits (x=5,y=9) -> after FRAME_CYCLES, start_sending high 132 cycles;
//     data_xaxis[5]=3, data_yaxis[9]=3 while high; all bins 0 afterwards; frame_count=1.
//  2. Preload bin_x[0]=FFFE, 4 hits x=0 -> bin stays FFFF.
//  3. 10 hits during DUMP -> lost_hits=10; bins unchanged until CLEARBINS.
//  4. command=2 mid-frame -> acquiring=0 within 4 clk; no start_sending; bins retained.
//  5. command glitch 1->2 for one clk then back to 1 -> no action taken.
//  6. Full loop with UsbController model: 128 reads (idx 127..0) match the bins;
//     controller returns to WAIT_START_SENDING_UP before the next frame.

Source files
------------

// File: rtl/axis_histogram_accumulator_pkg.sv
// Shared constants, types and helpers for the hit histogram accumulator.
// The command codes match the USB controller's command word encoding.
package axis_histogram_accumulator_pkg;

  localparam int BIN_COUNT = 128;
  localparam int BIN_W     = 16;
  localparam int IDX_W     = 7;
  localparam int CMD_W     = 16;

  localparam logic [CMD_W-1:0] CMD_NOOP  = 16'd0;
  localparam logic [CMD_W-1:0] CMD_START = 16'd1;
  localparam logic [CMD_W-1:0] CMD_STOP  = 16'd2;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_DUMP,
    ST_CLEARBINS
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_START,
    PEND_STOP,
    PEND_CLEAR
  } pend_e;

  typedef logic [BIN_COUNT-1:0][BIN_W-1:0] bins_t;

  function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_histogram_accumulator_cmd_sync.sv
// Brings the host command word into the clk domain and turns each stable,
// newly accepted value into a one-cycle action pulse.
module axis_histogram_accumulator_cmd_sync
  import axis_histogram_accumulator_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] command,
  output logic             start_p,
  output logic             stop_p,
  output logic             clear_p
);

  logic [CMD_W-1:0] sync1_q, sync1_d;
  logic [CMD_W-1:0] sync2_q, sync2_d;
  logic [CMD_W-1:0] samp_q,  samp_d;
  logic [CMD_W-1:0] acc_q,   acc_d;
  logic             change;

  // A value is taken only after two equal synchronised samples, so a
  // single-cycle glitch on the bus never produces an action.
  always_comb begin
    sync1_d = command;
    sync2_d = sync1_q;
    samp_d  = sync2_q;
    change  = (sync2_q == samp_q) && (sync2_q != acc_q);
    acc_d   = change ? sync2_q : acc_q;
    start_p = change && (sync2_q == CMD_START);
    stop_p  = change && (sync2_q == CMD_STOP);
    clear_p = change && (sync2_q == CMD_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= CMD_NOOP;
      sync2_q <= CMD_NOOP;
      samp_q  <= CMD_NOOP;
      acc_q   <= CMD_NOOP;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/axis_histogram_accumulator.sv
// Bins detector hits into x/y projections over a fixed frame, then holds the
// bins frozen while start_sending tells the USB controller to read them out.
module axis_histogram_accumulator
  import axis_histogram_accumulator_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 1_000_000,
  parameter int unsigned DUMP_CYCLES  = 132
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_x,
  input  logic [IDX_W-1:0] hit_y,
  input  logic [CMD_W-1:0] command,
  input  logic [IDX_W-1:0] read_index_yaxis,
  input  logic [IDX_W-1:0] read_index_xaxis,
  output logic [BIN_W-1:0] data_yaxis,
  output logic [BIN_W-1:0] data_xaxis,
  output logic             start_sending,
  output logic             acquiring,
  output logic [15:0]      frame_count,
  output logic [15:0]      lost_hits
);

  localparam int TIMER_W = $clog2(FRAME_CYCLES);
  localparam int DUMP_W  = $clog2(DUMP_CYCLES);

  logic start_p, stop_p, clear_p;

  axis_histogram_accumulator_cmd_sync u_cmd_sync (
    .clk     (clk),
    .reset   (reset),
    .command (command),
    .start_p (start_p),
    .stop_p  (stop_p),
    .clear_p (clear_p)
  );

  state_e             state_q, state_d;
  pend_e              pend_q, pend_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DUMP_W-1:0]  dump_cnt_q, dump_cnt_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [15:0]        lost_hits_q, lost_hits_d;
  logic               start_sending_q, start_sending_d;
  logic               acquiring_q, acquiring_d;
  bins_t              bins_x_q, bins_x_d;
  bins_t              bins_y_q, bins_y_d;

  pend_e cmd_now, cmd_eff;
  logic  lost_inc, zero_bins, zero_counters;

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    timer_d         = timer_q;
    dump_cnt_d      = dump_cnt_q;
    frame_count_d   = frame_count_q;
    lost_hits_d     = lost_hits_q;
    start_sending_d = start_sending_q;
    acquiring_d     = acquiring_q;
    bins_x_d        = bins_x_q;
    bins_y_d        = bins_y_q;
    lost_inc        = 1'b0;
    zero_bins       = 1'b0;
    zero_counters   = 1'b0;

    cmd_now = start_p ? PEND_START :
              stop_p  ? PEND_STOP  :
              clear_p ? PEND_CLEAR : PEND_NONE;
    // The freshest command wins over one latched earlier in the dump.
    cmd_eff = (cmd_now != PEND_NONE) ? cmd_now : pend_q;

    unique case (state_q)
      ST_IDLE: begin
        lost_inc = hit_valid;
        if (start_p) begin
          zero_bins   = 1'b1;
          timer_d     = '0;
          state_d     = ST_ACQUIRE;
          acquiring_d = 1'b1;
        end else if (clear_p) begin
          zero_bins     = 1'b1;
          zero_counters = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (hit_valid) begin
          bins_x_d[hit_x] = sat_inc(bins_x_q[hit_x]);
          bins_y_d[hit_y] = sat_inc(bins_y_q[hit_y]);
        end
        // Commands outrank the frame end, so a STOP on the last cycle cancels the dump.
        if (stop_p) begin
          state_d     = ST_IDLE;
          acquiring_d = 1'b0;
        end else if (clear_p) begin
          zero_bins     = 1'b1;
          zero_counters = 1'b1;
          timer_d       = '0;
        end else if (timer_q == TIMER_W'(FRAME_CYCLES - 1)) begin
          state_d         = ST_DUMP;
          start_sending_d = 1'b1;
          acquiring_d     = 1'b0;
          dump_cnt_d      = '0;
          pend_d          = PEND_NONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DUMP: begin
        lost_inc = hit_valid;
        if (cmd_now != PEND_NONE) pend_d = cmd_now;
        if (dump_cnt_q == DUMP_W'(DUMP_CYCLES - 1)) begin
          state_d         = ST_CLEARBINS;
          start_sending_d = 1'b0;
          frame_count_d   = frame_count_q + 16'd1;
        end else begin
          dump_cnt_d = dump_cnt_q + 1'b1;
        end
      end
      ST_CLEARBINS: begin
        lost_inc  = hit_valid;
        zero_bins = 1'b1;
        pend_d    = PEND_NONE;
        if (cmd_eff == PEND_STOP) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_ACQUIRE;
          acquiring_d   = 1'b1;
          timer_d       = '0;
          zero_counters = (cmd_eff == PEND_CLEAR);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (lost_inc) lost_hits_d = sat_inc(lost_hits_q);
    if (zero_counters) begin
      frame_count_d = '0;
      lost_hits_d   = '0;
    end
    if (zero_bins) begin
      bins_x_d = '0;
      bins_y_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pend_q          <= PEND_NONE;
      timer_q         <= '0;
      dump_cnt_q      <= '0;
      frame_count_q   <= '0;
      lost_hits_q     <= '0;
      start_sending_q <= 1'b0;
      acquiring_q     <= 1'b0;
      bins_x_q        <= '0;
      bins_y_q        <= '0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      timer_q         <= timer_d;
      dump_cnt_q      <= dump_cnt_d;
      frame_count_q   <= frame_count_d;
      lost_hits_q     <= lost_hits_d;
      start_sending_q <= start_sending_d;
      acquiring_q     <= acquiring_d;
      bins_x_q        <= bins_x_d;
      bins_y_q        <= bins_y_d;
    end
  end

  assign data_yaxis    = bins_y_q[read_index_yaxis];
  assign data_xaxis    = bins_x_q[read_index_xaxis];
  assign start_sending = start_sending_q;
  assign acquiring     = acquiring_q;
  assign frame_count   = frame_count_q;
  assign lost_hits     = lost_hits_q;

endmodule

// File: tb/tb_axis_histogram_accumulator.sv
// Directed bench for the histogram accumulator; a second instance with a long
// frame is used for the bin saturation scenario.
module tb_axis_histogram_accumulator;

  localparam int FC = 200;
  localparam int DC = 132;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        hit_valid, s_hit_valid;
  logic [6:0]  hit_x, hit_y, rix, riy, s_hit_x, s_hit_y, s_rix, s_riy;
  logic [15:0] command, s_command;
  logic [15:0] dx, dy, fcnt, lost, s_dx, s_dy, s_fcnt, s_lost;
  logic        ss, acq, s_ss, s_acq;

  int total = 0;
  int bad   = 0;

  typedef enum logic [1:0] {WAIT_START_SENDING_UP, READING, WAIT_START_SENDING_DOWN} usb_e;
  usb_e usb_state;

  axis_histogram_accumulator #(.FRAME_CYCLES(FC), .DUMP_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .command(command), .read_index_yaxis(riy), .read_index_xaxis(rix),
    .data_yaxis(dy), .data_xaxis(dx), .start_sending(ss), .acquiring(acq),
    .frame_count(fcnt), .lost_hits(lost)
  );

  axis_histogram_accumulator #(.FRAME_CYCLES(70000), .DUMP_CYCLES(DC)) dut_sat (
    .clk(clk), .reset(reset), .hit_valid(s_hit_valid), .hit_x(s_hit_x), .hit_y(s_hit_y),
    .command(s_command), .read_index_yaxis(s_riy), .read_index_xaxis(s_rix),
    .data_yaxis(s_dy), .data_xaxis(s_dx), .start_sending(s_ss), .acquiring(s_acq),
    .frame_count(s_fcnt), .lost_hits(s_lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hit_valid = 0; hit_x = 0; hit_y = 0; command = 0; rix = 0; riy = 0;
    s_hit_valid = 0; s_hit_x = 0; s_hit_y = 0; s_command = 0; s_rix = 0; s_riy = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++;
    if (acq !== 1'b0 || ss !== 1'b0 || s_acq !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: acq=%b ss=%b s_acq=%b want 0 0 0", acq, ss, s_acq);
    end
    total++;
    if (fcnt !== 16'd0 || lost !== 16'd0 || dx !== 16'd0 || dy !== 16'd0) begin
      bad++; $display("FAIL reset_cnt: fcnt=%h lost=%h dx=%h dy=%h want all 0", fcnt, lost, dx, dy);
    end
  endtask

  task automatic test_frame();
    int n, cnt, errs, nz;
    rix = 7'd5; riy = 7'd9;
    command = 16'd1;
    n = 0;
    while (!acq && n < 10) begin tick(); n++; end
    total++;
    if (acq !== 1'b1 || n > 4) begin
      bad++; $display("FAIL start_latency: got %0d cycles acq=%b want <=4 acq=1", n, acq);
    end
    hit_valid = 1; hit_x = 7'd5; hit_y = 7'd9;
    repeat (3) tick();
    hit_valid = 0;
    n = 3;
    while (!ss && n < FC + 20) begin tick(); n++; end
    total++;
    if (n !== FC) begin
      bad++; $display("FAIL frame_len: got %0d want %0d", n, FC);
    end
    cnt = 0; errs = 0;
    while (ss && cnt < DC + 20) begin
      if (dx !== 16'd3 || dy !== 16'd3) errs++;
      cnt++;
      tick();
    end
    total++;
    if (cnt !== DC) begin
      bad++; $display("FAIL dump_len: got %0d want %0d", cnt, DC);
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL dump_data: %0d bad reads want x5=3 y9=3", errs);
    end
    tick();
    total++;
    if (acq !== 1'b1 || fcnt !== 16'd1) begin
      bad++; $display("FAIL after_dump: acq=%b fcnt=%0d want 1 1", acq, fcnt);
    end
    nz = 0;
    for (int i = 0; i < 128; i++) begin
      rix = 7'(i); riy = 7'(i); #1;
      if (dx !== 16'd0 || dy !== 16'd0) nz++;
    end
    total++;
    if (nz !== 0) begin
      bad++; $display("FAIL bins_cleared: %0d nonzero bins want 0", nz);
    end
  endtask

  task automatic test_glitch();
    int errs;
    tick();
    command = 16'd2;
    tick();
    command = 16'd1;
    errs = 0;
    repeat (8) begin
      tick();
      if (acq !== 1'b1 || ss !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL glitch: %0d cycles left ACQUIRE want 0", errs);
    end
  endtask

  task automatic test_stop_mid_frame();
    int n, errs;
    rix = 7'd20; riy = 7'd30;
    hit_valid = 1; hit_x = 7'd20; hit_y = 7'd30;
    repeat (2) tick();
    hit_valid = 0;
    command = 16'd2;
    n = 0;
    while (acq && n < 10) begin tick(); n++; end
    total++;
    if (acq !== 1'b0 || n > 4) begin
      bad++; $display("FAIL stop_latency: got %0d cycles acq=%b want <=4 acq=0", n, acq);
    end
    errs = 0;
    repeat (FC + 50) begin
      tick();
      if (ss !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL stop_no_dump: start_sending high %0d cycles want 0", errs);
    end
    total++;
    if (dx !== 16'd2 || dy !== 16'd2 || lost !== 16'd0) begin
      bad++; $display("FAIL stop_retain: dx=%0d dy=%0d lost=%0d want 2 2 0", dx, dy, lost);
    end
  endtask

  task automatic test_dump_hits();
    int n;
    command = 16'd1;
    n = 0;
    while (!acq && n < 10) begin tick(); n++; end
    total++;
    if (acq !== 1'b1 || dx !== 16'd0) begin
      bad++; $display("FAIL restart: acq=%b dx=%0d want 1 0", acq, dx);
    end
    rix = 7'd7; riy = 7'd8;
    hit_valid = 1; hit_x = 7'd7; hit_y = 7'd8;
    tick();
    hit_valid = 0;
    n = 0;
    while (!ss && n < FC + 20) begin tick(); n++; end
    hit_valid = 1;
    repeat (10) tick();
    hit_valid = 0;
    total++;
    if (lost !== 16'd10 || dx !== 16'd1 || dy !== 16'd1 || ss !== 1'b1) begin
      bad++; $display("FAIL dump_lost: lost=%0d dx=%0d dy=%0d ss=%b want 10 1 1 1", lost, dx, dy, ss);
    end
    command = 16'd2;
    n = 0;
    while (ss && n < DC + 20) begin tick(); n++; end
    total++;
    if (ss !== 1'b0 || dx !== 16'd1) begin
      bad++; $display("FAIL clearbins_hold: ss=%b dx=%0d want 0 1", ss, dx);
    end
    tick();
    total++;
    if (dx !== 16'd0 || acq !== 1'b0 || fcnt !== 16'd2) begin
      bad++; $display("FAIL pend_stop: dx=%0d acq=%b fcnt=%0d want 0 0 2", dx, acq, fcnt);
    end
  endtask

  task automatic test_clear_idle();
    command = 16'd3;
    repeat (6) tick();
    total++;
    if (fcnt !== 16'd0 || lost !== 16'd0 || acq !== 1'b0) begin
      bad++; $display("FAIL clear_idle: fcnt=%0d lost=%0d acq=%b want 0 0 0", fcnt, lost, acq);
    end
  endtask

  task automatic test_usb_loop();
    int ex[128];
    int ey[128];
    int n, mx, my, off;
    for (int i = 0; i < 128; i++) begin ex[i] = 0; ey[i] = 0; end
    usb_state = WAIT_START_SENDING_UP;
    command = 16'd1;
    n = 0;
    while (!acq && n < 10) begin tick(); n++; end
    for (int k = 0; k < FC; k++) begin
      hit_valid = 1; hit_x = 7'(k % 128); hit_y = 7'((k * 3) % 128);
      ex[k % 128]++; ey[(k * 3) % 128]++;
      tick();
    end
    hit_x = 7'd0; hit_y = 7'd0;
    tick();
    hit_valid = 0;
    total++;
    if (ss !== 1'b1 || lost !== 16'd1) begin
      bad++; $display("FAIL last_cycle_hit: ss=%b lost=%0d want 1 1", ss, lost);
    end
    if (ss) usb_state = READING;
    mx = 0; my = 0; off = 0;
    for (int idx = 127; idx >= 0; idx--) begin
      rix = 7'(idx); riy = 7'(idx); #1;
      if (dx !== 16'(ex[idx])) mx++;
      if (dy !== 16'(ey[idx])) my++;
      if (!ss) off++;
      tick();
    end
    usb_state = WAIT_START_SENDING_DOWN;
    total++;
    if (mx !== 0 || my !== 0 || off !== 0) begin
      bad++; $display("FAIL usb_reads: xbad=%0d ybad=%0d ss_low=%0d want 0 0 0", mx, my, off);
    end
    n = 0;
    while (ss && n < DC + 20) begin tick(); n++; end
    if (!ss) usb_state = WAIT_START_SENDING_UP;
    tick();
    total++;
    if (usb_state !== WAIT_START_SENDING_UP || acq !== 1'b1 || fcnt !== 16'd1) begin
      bad++; $display("FAIL usb_return: usb=%0d acq=%b fcnt=%0d want 0 1 1", usb_state, acq, fcnt);
    end
    command = 16'd2;
    repeat (6) tick();
  endtask

  task automatic test_saturate();
    int n;
    s_command = 16'd1;
    n = 0;
    while (!s_acq && n < 10) begin tick(); n++; end
    s_hit_valid = 1; s_hit_x = 7'd0; s_hit_y = 7'd0;
    repeat (65534) tick();
    total++;
    if (s_dx !== 16'hFFFE) begin
      bad++; $display("FAIL sat_preload: got %h want FFFE", s_dx);
    end
    repeat (4) tick();
    s_hit_valid = 0;
    total++;
    if (s_dx !== 16'hFFFF || s_dy !== 16'hFFFF || s_ss !== 1'b0) begin
      bad++; $display("FAIL saturate: dx=%h dy=%h ss=%b want FFFF FFFF 0", s_dx, s_dy, s_ss);
    end
    s_command = 16'd2;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_stop_mid_frame();
    test_dump_hits();
    test_clear_idle();
    test_usb_loop();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
